fib_decimal_printer: RTL and testbench

- Downstream consumer of the Fibonacci generator's 32-bit result and its completion flag.
- On a rising edge of the completion flag, latches the value and converts it to decimal with a sequential double-dabble.
- Streams the ASCII digits, most significant first with leading zeros suppressed, then CR LF, over a byte valid/ready handshake into the UART transmitter.

---
 rtl/fib_decimal_printer_pkg.sv | 24 ++
 rtl/fib_decimal_printer_if.sv | 28 ++
 rtl/fib_decimal_printer_bin2bcd_seq.sv | 68 ++++++
 rtl/fib_decimal_printer.sv | 158 +++++++++++++++
 tb/tb_fib_decimal_printer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fib_decimal_printer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_decimal_printer_pkg
// Description : Shared types and constants for the Fibonacci decimal printer.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_decimal_printer_pkg;

  // Printer sequencing states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    EMIT    = 3'd2,
    CR      = 3'd3,
    LF      = 3'd4,
    FINISH  = 3'd5
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage : fib_decimal_printer_pkg
`default_nettype wire

// File: rtl/fib_decimal_printer_if.sv
`default_nettype none
// ============================================================================
// Module      : fib_decimal_printer_if
// Description : Byte valid/ready stream from the printer to the UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
interface fib_decimal_printer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Byte producer (printer)
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Byte consumer (UART transmitter)
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface : fib_decimal_printer_if
`default_nettype wire

// File: rtl/fib_decimal_printer_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble, one input bit per clock. A load
//               starts a WIDTH-cycle conversion; bcd_valid marks the cycle
//               of the final shift, so bcd is complete from the next cycle
//               and is held until the following load.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [4*DIGITS-1:0] w_adj;

  // Add-3 correction on every nibble that would overflow past 9 after shifting
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign w_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                              (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
  end

  // Next-state: load a new value, or perform one correct-then-shift step
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    if (load) begin
      cnt_d   = CNT_W'(WIDTH);
      shreg_d = bin;
      bcd_d   = '0;
    end else if (cnt_q != '0) begin
      bcd_d   = {w_adj[4*DIGITS-2:0], shreg_q[WIDTH-1]};
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  // Conversion registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      bcd_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = (cnt_q == CNT_W'(1));

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/fib_decimal_printer.sv
`default_nettype none
// ============================================================================
// Module      : fib_decimal_printer
// Description : On a rising edge of start, converts value to decimal and
//               streams the ASCII digits (leading zeros suppressed), then
//               optionally CR LF, over a byte valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_decimal_printer
  import fib_decimal_printer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 10,
  parameter int APPEND_CRLF = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  fib_decimal_printer_if.master tx,
  output logic                  busy,
  output logic                  done
);

  localparam int             IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] C_IDX_TOP = IDX_W'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                seen_q, seen_d;   // a nonzero digit has been sent
  logic                gap_q, gap_d;     // idle cycle after every transfer
  logic                start_q;
  logic                busy_q;
  logic                done_q;

  logic                w_edge;
  logic                w_load;
  logic [4*DIGITS-1:0] w_bcd;
  logic                w_bcd_valid;
  logic [4*DIGITS-1:0] w_bcd_sh;
  logic [3:0]          w_digit;
  logic                w_tx_valid;
  logic [7:0]          w_tx_data;

  assign w_edge   = start & ~start_q;
  assign w_bcd_sh = w_bcd >> {idx_q, 2'b00};
  assign w_digit  = w_bcd_sh[3:0];

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .bin       (value),
    .bcd       (w_bcd),
    .bcd_valid (w_bcd_valid)
  );

  // Sequencer: edge accept, conversion wait, digit skip/send, CR LF, done
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seen_d     = seen_q;
    gap_d      = 1'b0;
    w_load     = 1'b0;
    w_tx_valid = 1'b0;
    w_tx_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (w_edge) begin
          w_load  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (w_bcd_valid) begin
          state_d = EMIT;
          idx_d   = C_IDX_TOP;
          seen_d  = 1'b0;
        end
      end
      EMIT: begin
        if (!gap_q) begin
          if (!seen_q && (w_digit == 4'h0) && (idx_q != '0)) begin
            idx_d = idx_q - IDX_W'(1);
          end else begin
            w_tx_valid = 1'b1;
            w_tx_data  = ASCII_ZERO + {4'h0, w_digit};
            if (tx.tx_ready) begin
              seen_d = 1'b1;
              gap_d  = 1'b1;
              if (idx_q == '0) begin
                state_d = (APPEND_CRLF != 0) ? CR : FINISH;
              end else begin
                idx_d = idx_q - IDX_W'(1);
              end
            end
          end
        end
      end
      CR: begin
        if (!gap_q) begin
          w_tx_valid = 1'b1;
          w_tx_data  = ASCII_CR;
          if (tx.tx_ready) begin
            gap_d   = 1'b1;
            state_d = LF;
          end
        end
      end
      LF: begin
        if (!gap_q) begin
          w_tx_valid = 1'b1;
          w_tx_data  = ASCII_LF;
          if (tx.tx_ready) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      seen_q  <= 1'b0;
      gap_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seen_q  <= seen_d;
      gap_q   <= gap_d;
      start_q <= start;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FINISH);
    end
  end

  assign tx.tx_valid = w_tx_valid;
  assign tx.tx_data  = w_tx_data;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule : fib_decimal_printer
`default_nettype wire

// File: tb/tb_fib_decimal_printer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_decimal_printer
// Description : Self-checking bench for fib_decimal_printer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_decimal_printer;

  typedef struct {
    logic [31:0] value;
    string       text;
    int          ready_mode;   // 1 = always ready, 2 = random
    bit          glitch;       // re-raise start while printing
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        tx_ready;
  logic        busy;
  logic        done;
  int          ready_mode;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  fib_decimal_printer_if u_if ();
  assign u_if.tx_ready = tx_ready;

  fib_decimal_printer #(
    .WIDTH       (32),
    .DIGITS      (10),
    .APPEND_CRLF (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .tx    (u_if),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Ready generator, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       tx_ready = 1'b1;
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every transferred byte must match the queue head,
  // and a stalled byte must stay presented and unchanged
  always @(negedge clk) begin
    if (!rst && prev_valid && !prev_ready) begin
      check("hold_valid", {31'd0, u_if.tx_valid}, 32'd1);
      check("hold_data", {24'd0, u_if.tx_data}, {24'd0, prev_data});
    end
    if (!rst && u_if.tx_valid && tx_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL tx_byte: got %02h expected no byte", u_if.tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (u_if.tx_data === e) n_pass++;
        else $display("FAIL tx_byte: got %02h expected %02h", u_if.tx_data, e);
      end
    end
    prev_valid = u_if.tx_valid;
    prev_ready = tx_ready;
    prev_data  = u_if.tx_data;
  end

  task automatic push_text(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Wait (bounded) for done; returns 1 if seen
  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_print(input vec_t v);
    int cyc;
    int first;
    int lat;
    bit got;
    start = 1'b0;
    ready_mode = v.ready_mode;
    repeat (2) @(posedge clk);
    #1;
    // first tx_valid at T + WIDTH + 1 + number of suppressed leading zeros
    lat = 33 + (10 - v.text.len());
    push_text(v.text);
    value = v.value;
    start = 1'b1;
    first = -1;
    got   = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("busy_high", {31'd0, busy}, 32'd1);
      if (first < 0 && u_if.tx_valid) first = cyc;
      if (v.glitch && first >= 0 && cyc == first + 2) start = 1'b0;
      if (v.glitch && first >= 0 && cyc == first + 4) begin
        start = 1'b1;
        value = 32'd99;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({"done_seen_", v.text}, {31'd0, got}, 32'd1);
    check({"first_valid_", v.text}, first, lat);
    check({"queue_drained_", v.text}, exp_q.size(), 32'd0);
    @(negedge clk);
    check("done_single", {31'd0, done}, 32'd0);
    check("busy_low", {31'd0, busy}, 32'd0);
    // nothing further may be printed (ignored edges are lost)
    got = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (u_if.tx_valid) got = 1'b1;
    end
    check({"quiet_after_", v.text}, {31'd0, got}, 32'd0);
    exp_q.delete();
  endtask

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    vecs[0] = '{32'd1,          "1",          1, 1'b0};
    vecs[1] = '{32'd0,          "0",          1, 1'b0};
    vecs[2] = '{32'd2971215073, "2971215073", 1, 1'b0};
    vecs[3] = '{32'hFFFFFFFF,   "4294967295", 2, 1'b0};
    vecs[4] = '{32'd1234,       "1234",       2, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    value = 32'd0;
    tx_ready = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", {31'd0, u_if.tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, u_if.tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) run_print(vecs[i]);

    // Reset while the second digit of 1234 is stalled
    start = 1'b0;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(8'h31);
    value = 32'd1234;
    start = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (u_if.tx_valid && tx_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_seq_first_byte", {31'd0, got}, 32'd1);
    ready_mode = 0;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (u_if.tx_valid && u_if.tx_data == 8'h32) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_seq_second_byte", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    value = 32'd4321;
    @(negedge clk);
    @(negedge clk);
    check("rst_abort_valid", {31'd0, u_if.tx_valid}, 32'd0);
    check("rst_abort_done", {31'd0, done}, 32'd0);
    check("rst_abort_queue", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_text("4321");
    ready_mode = 1;
    wait_done(got);
    check("rst_reprint_done", {31'd0, got}, 32'd1);
    check("rst_reprint_queue", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fib_decimal_printer
`default_nettype wire
